adc_cfg_seq: RTL and testbench
==============================

Name: adc_cfg_seq

Overview:
Configuration sequencer for the ADS5292 ADC serial register port. It drives the register-word selector (init_reg, incr_reg, auto_run, pttn_sel) and captures the selected 24-bit word. It then serializes that word on the ADC SPI pins. It runs the power-up auto sequence, which ends on the deskew pattern, and also runs single manual writes requested by the DCM control logic.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
REG_W, 24, ADC register word width (address 8 + data 16)
MAX_AUTO, 8, auto-sequence write limit before abort

Ports:
clk  in  1  system clock
rstb  in  1  reset, asynchronous, active-low
start_auto  in  1  one-cycle pulse; starts auto sequence
man_req  in  1  level; manual single-write request, held until man_ack
man_sel  in  4  manual register selector code
man_ack  out  1  one-cycle pulse; manual request accepted or rejected
reg_word  in  REG_W  selected register word from selector
end_auto  in  1  selector flag: current word is the last auto word
init_reg  out  1  selector counter reset pulse
incr_reg  out  1  selector counter increment pulse
auto_run  out  1  selector mode: 1 = counter, 0 = pttn_sel
pttn_sel  out  4  manual selector code
spi_sclk  out  1  ADC SCLK, idle low
spi_sdata  out  1  ADC SDATA, MSB first
spi_sen_n  out  1  ADC SEN, active low
busy  out  1  sequencer not idle
done  out  1  one-cycle pulse; sequence or manual write complete
err  out  1  one-cycle pulse; invalid man_sel or auto limit hit

Behaviour:
- Reset values: spi_sen_n=1. All other outputs 0. Internal state is IDLE, with a write count of 0. Reset mid-transfer aborts immediately; no partial-frame recovery.
- State machine states: IDLE, INIT, SETTLE, SHIFT, GAP, NEXT.
- IDLE, start_auto: start_auto wins if it coincides with man_req. Go to INIT and set auto_run=1.
- INIT: pulse init_reg for one cycle, then go to SETTLE.
- IDLE, man_req, man_sel <= 4'hA: latch pttn_sel=man_sel, auto_run=0, pulse man_ack, then go to SETTLE.
- IDLE, man_req, man_sel > 4'hA: pulse man_ack and err in the same cycle. No SPI activity; stay in IDLE.
- Requests in any state other than IDLE are ignored. start_auto is not queued; man_req stays pending because it is a level.
- SETTLE: one cycle. Capture reg_word into the shift register and capture end_auto into last_flag. Go to SHIFT.
- SHIFT: drive spi_sen_n=0 and emit REG_W bits, MSB first.
  - The shift starts in the cycle after capture. spi_sdata changes only while spi_sclk is low.
  - Each bit is CLK_DIV cycles low, then CLK_DIV cycles high; the ADC samples on the rising edge.
  - A frame is REG_W*2*CLK_DIV cycles (192 at defaults).
- GAP: in the cycle after the last SCLK falling edge, set spi_sen_n=1, spi_sclk=0, spi_sdata=0. Hold for CLK_DIV cycles.
- NEXT, manual write: pulse done and return to IDLE.
- NEXT, auto write with last_flag=1: pulse done, clear auto_run, return to IDLE.
- NEXT, auto write with last_flag=0: increment the write count.
  - If the count reaches MAX_AUTO: pulse err, clear auto_run, return to IDLE, no done.
  - Otherwise: pulse incr_reg and return to SETTLE. The selector updates on that edge, so SETTLE captures the new word.
- busy=1 in every state except IDLE. pttn_sel holds its last manual value between writes.

Decomposition:
- Package adc_cfg_pkg holds:
  - state enum
  - selector codes: SEL_SBITS=1, SEL_DBITS=2, SEL_DESKEW=3, SEL_SYNC=4, SEL_SCUSTOM=5, SEL_DCUSTOM=6, SEL_RAMP=7, SEL_PWRDN=8, SEL_DEL25=9, SEL_DEL45=10, SEL_MAX=10
  - REG_W default
- Sub-module adc_spi_shifter: REG_W serializer with SCLK divider.
  - Inputs: load, word. Outputs: sclk, sdata, sen_n, frame_done.
  - The FSM stays in adc_cfg_seq.

Test Plan:
- Reset: drive rstb low mid-frame -> spi_sen_n=1 and spi_sclk=0 asynchronously. After release, busy=0 and no SPI edges until a request arrives.
- Auto sequence: drive start_auto with a behavioural selector model (counter starts at 1) -> init_reg pulses once and incr_reg pulses twice. Three frames are observed: 0x26AA80, 0x275540, 0x450001. Then done pulses and auto_run=0.
- Frame timing: with CLK_DIV=4, each frame is 192 cycles of spi_sen_n=0 with 24 rising edges. SDATA is stable for >=4 cycles around each rising edge, and the GAP is 4 cycles.
- Manual write: man_sel=4'h8 with pwdown_ch=8'h03 -> man_ack pulses, pttn_sel=8, auto_run=0. One frame 0x0F0203 is sent, then done pulses.
- Invalid and collision cases:
  - man_sel=4'hB -> man_ack and err pulse together; spi_sen_n stays high.
  - start_auto and man_req in the same cycle -> the auto sequence runs first; the manual write is acked after the auto done.
- Auto abort: selector model holds end_auto=0 -> exactly 8 frames are sent, then err pulses, no done, busy=0.

Source files
------------

// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADS5292 configuration sequencer.
package adc_cfg_pkg;

    localparam int unsigned REG_W_DEF = 24;

    // Selector codes understood by the external register-word selector
    localparam logic [3:0] SEL_SBITS   = 4'd1;
    localparam logic [3:0] SEL_DBITS   = 4'd2;
    localparam logic [3:0] SEL_DESKEW  = 4'd3;
    localparam logic [3:0] SEL_SYNC    = 4'd4;
    localparam logic [3:0] SEL_SCUSTOM = 4'd5;
    localparam logic [3:0] SEL_DCUSTOM = 4'd6;
    localparam logic [3:0] SEL_RAMP    = 4'd7;
    localparam logic [3:0] SEL_PWRDN   = 4'd8;
    localparam logic [3:0] SEL_DEL25   = 4'd9;
    localparam logic [3:0] SEL_DEL45   = 4'd10;
    localparam logic [3:0] SEL_MAX     = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SETTLE,
        ST_SHIFT,
        ST_GAP,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/adc_cfg_seq_shifter.sv
// MSB-first serializer for one ADC register word with an SCLK divider.
// o_frame_done is high during the last cycle that o_sen_n is low.
module adc_spi_shifter
    import adc_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned REG_W   = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_load,
    input  logic [REG_W-1:0] i_word,
    output logic             o_sclk,
    output logic             o_sdata,
    output logic             o_sen_n,
    output logic             o_frame_done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(REG_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REG_W - 1);

    logic             r_active;
    logic             r_sclk;
    logic             r_sdata;
    logic             r_sen_n;
    logic             r_done;
    logic [REG_W-1:0] r_shreg;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
            r_sdata  <= 1'b0;
            r_sen_n  <= 1'b1;
            r_done   <= 1'b0;
            r_shreg  <= '0;
            r_div    <= '0;
            r_bit    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_active <= 1'b1;
                r_sen_n  <= 1'b0;
                r_sclk   <= 1'b0;
                r_sdata  <= i_word[REG_W-1];
                r_shreg  <= {i_word[REG_W-2:0], 1'b0};
                r_div    <= '0;
                r_bit    <= '0;
            end else if (r_active) begin
                if (r_div == DIV_LAST) begin
                    r_div <= '0;
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        // falling edge: next bit goes out while SCLK is low
                        r_sclk <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_active <= 1'b0;
                            r_sen_n  <= 1'b1;
                            r_sdata  <= 1'b0;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_sdata <= r_shreg[REG_W-1];
                            r_shreg <= {r_shreg[REG_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                    if (r_sclk && (r_bit == BIT_LAST) && (r_div == DIV_PRE)) begin
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_sclk       = r_sclk;
    assign o_sdata      = r_sdata;
    assign o_sen_n      = r_sen_n;
    assign o_frame_done = r_done;

endmodule

// File: rtl/adc_cfg_seq.sv
// ADS5292 configuration sequencer: power-up auto sequence and single manual
// register writes, driving the external word selector and the ADC SPI pins.
module adc_cfg_seq
    import adc_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned MAX_AUTO = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start_auto,
    input  logic             man_req,
    input  logic [3:0]       man_sel,
    output logic             man_ack,
    input  logic [REG_W-1:0] reg_word,
    input  logic             end_auto,
    output logic             init_reg,
    output logic             incr_reg,
    output logic             auto_run,
    output logic [3:0]       pttn_sel,
    output logic             spi_sclk,
    output logic             spi_sdata,
    output logic             spi_sen_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(MAX_AUTO + 1);
    localparam int unsigned GAP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_AUTO);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CLK_DIV - 1);

    state_t           r_state;
    logic             r_init_reg;
    logic             r_incr_reg;
    logic             r_auto_run;
    logic [3:0]       r_pttn_sel;
    logic             r_man_ack;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_last;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic             w_load;
    logic             w_frame_done;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_load    = (r_state == ST_SETTLE);
    assign w_cnt_nxt = r_wr_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_init_reg <= 1'b0;
            r_incr_reg <= 1'b0;
            r_auto_run <= 1'b0;
            r_pttn_sel <= 4'd0;
            r_man_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
            r_wr_cnt   <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_init_reg <= 1'b0;
            r_incr_reg <= 1'b0;
            r_man_ack  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_auto) begin
                        r_state    <= ST_INIT;
                        r_auto_run <= 1'b1;
                        r_init_reg <= 1'b1;
                        r_wr_cnt   <= '0;
                        r_busy     <= 1'b1;
                    end else if (man_req && !r_man_ack) begin
                        // the ack cycle masks the still-high level request
                        r_man_ack <= 1'b1;
                        if (man_sel <= SEL_MAX) begin
                            r_pttn_sel <= man_sel;
                            r_auto_run <= 1'b0;
                            r_state    <= ST_SETTLE;
                            r_busy     <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_last  <= end_auto;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_frame_done) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        // NEXT-cycle pulses are decided here so they are high during NEXT
                        r_state <= ST_NEXT;
                        if (!r_auto_run || r_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_wr_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == CNT_MAX) begin
                                r_err <= 1'b1;
                            end else begin
                                r_incr_reg <= 1'b1;
                            end
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (r_incr_reg) begin
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_auto_run <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    adc_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .REG_W   (REG_W)
    ) u_shifter (
        .clk          (clk),
        .rstb         (rstb),
        .i_load       (w_load),
        .i_word       (reg_word),
        .o_sclk       (spi_sclk),
        .o_sdata      (spi_sdata),
        .o_sen_n      (spi_sen_n),
        .o_frame_done (w_frame_done)
    );

    assign init_reg = r_init_reg;
    assign incr_reg = r_incr_reg;
    assign auto_run = r_auto_run;
    assign pttn_sel = r_pttn_sel;
    assign man_ack  = r_man_ack;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Bench for adc_cfg_seq: behavioural word selector, SPI frame monitor and scoreboard.
module tb_adc_cfg_seq;
    import adc_cfg_pkg::*;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned REG_W     = 24;
    localparam int unsigned MAX_AUTO  = 8;
    localparam int unsigned FRAME_CYC = REG_W * 2 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             start_auto = 1'b0;
    logic             man_req = 1'b0;
    logic [3:0]       man_sel = 4'd0;
    logic             man_ack;
    logic [REG_W-1:0] reg_word;
    logic             end_auto;
    logic             init_reg, incr_reg, auto_run;
    logic [3:0]       pttn_sel;
    logic             spi_sclk, spi_sdata, spi_sen_n;
    logic             busy, done, err;

    always #5 clk = ~clk;

    adc_cfg_seq #(.CLK_DIV(CLK_DIV), .REG_W(REG_W), .MAX_AUTO(MAX_AUTO)) dut (
        .clk(clk), .rstb(rstb), .start_auto(start_auto), .man_req(man_req),
        .man_sel(man_sel), .man_ack(man_ack), .reg_word(reg_word), .end_auto(end_auto),
        .init_reg(init_reg), .incr_reg(incr_reg), .auto_run(auto_run), .pttn_sel(pttn_sel),
        .spi_sclk(spi_sclk), .spi_sdata(spi_sdata), .spi_sen_n(spi_sen_n),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural register-word selector
    logic [7:0] sel_cnt;
    logic       no_end = 1'b0;
    logic [7:0] pwdown_ch = 8'h03;

    function automatic logic [23:0] auto_word(input logic [7:0] c);
        case (c)
            8'd1:    return 24'h26AA80;
            8'd2:    return 24'h275540;
            8'd3:    return 24'h450001;
            default: return {16'h6000, c};
        endcase
    endfunction

    function automatic logic [23:0] man_word(input logic [3:0] s, input logic [7:0] pw);
        if (s == SEL_PWRDN) return {16'h0F02, pw};
        return {20'h25000, s};
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb)         sel_cnt <= 8'd1;
        else if (init_reg) sel_cnt <= 8'd1;
        else if (incr_reg) sel_cnt <= 8'(sel_cnt + 8'd1);
    end

    assign reg_word = auto_run ? auto_word(sel_cnt) : man_word(pttn_sel, pwdown_ch);
    assign end_auto = auto_run && !no_end && (sel_cnt == 8'd3);

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI monitor: decodes frames on the falling clock edge and scores them
    int n_frames = 0, n_rise = 0, n_init = 0, n_incr = 0, n_done = 0, n_err = 0, n_ack = 0;
    initial begin
        logic        in_frame, prev_sclk, prev_sdata;
        int          fr_cyc, fr_rise, fr_bad, stable, gap;
        logic [23:0] fr_word, exp_w;
        in_frame = 1'b0; prev_sclk = 1'b0; prev_sdata = 1'b0;
        fr_cyc = 0; fr_rise = 0; fr_bad = 0; stable = 0; gap = 0; fr_word = '0;
        forever begin
            @(negedge clk);
            if (!rstb) begin
                in_frame = 1'b0; prev_sclk = 1'b0; prev_sdata = 1'b0;
            end else begin
                if (init_reg) n_init++;
                if (done)     n_done++;
                if (err)      n_err++;
                if (man_ack)  n_ack++;
                if (incr_reg) begin
                    n_incr++;
                    check("gap_cycles", 32'(gap), 32'(CLK_DIV));
                end
                if (!spi_sen_n) begin
                    if (!in_frame) begin
                        in_frame = 1'b1; fr_cyc = 0; fr_rise = 0; fr_bad = 0; stable = 1; fr_word = '0;
                    end else begin
                        if (spi_sclk && !prev_sclk) begin
                            if (stable < int'(CLK_DIV)) fr_bad++;
                            fr_word = {fr_word[22:0], spi_sdata};
                            fr_rise++;
                            n_rise++;
                        end
                        if (spi_sdata != prev_sdata) begin
                            if (spi_sclk) fr_bad++;
                            stable = 1;
                        end else begin
                            stable++;
                        end
                    end
                    fr_cyc++;
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    n_frames++;
                    gap = 1;
                    check("frame_cycles", 32'(fr_cyc), 32'(FRAME_CYC));
                    check("frame_rises", 32'(fr_rise), 32'(REG_W));
                    check("sdata_stable", 32'(fr_bad), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL frame_word: got 0x%06h, required no frame", fr_word);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("frame_word", 32'(fr_word), 32'(exp_w));
                    end
                end else begin
                    gap++;
                end
                prev_sclk  = spi_sclk;
                prev_sdata = spi_sdata;
            end
        end
    end

    // which: 0 done, 1 man_ack, 2 err, 3 spi_sen_n low
    task automatic wait_evt(input int which, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = done;
                1:       hit = man_ack;
                2:       hit = err;
                default: hit = !spi_sen_n;
            endcase
        end
        if (!hit) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got timeout, required event within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_auto = 1'b1;
        @(negedge clk);
        start_auto = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  pw;
        bit          valid;
        logic [23:0] word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int b_init, b_incr, b_done, b_err, b_ack, b_fr, b_rise;

        vecs[0] = '{SEL_PWRDN,  8'h03, 1'b1, 24'h0F0203};
        vecs[1] = '{4'hB,       8'h00, 1'b0, 24'h000000};
        vecs[2] = '{4'h0,       8'h00, 1'b1, 24'h250000};
        vecs[3] = '{SEL_MAX,    8'h00, 1'b1, 24'h25000A};
        vecs[4] = '{4'hF,       8'h00, 1'b0, 24'h000000};
        vecs[5] = '{SEL_DESKEW, 8'h00, 1'b1, 24'h250003};

        repeat (3) @(negedge clk);
        check("rst_sen_n", 32'(spi_sen_n), 32'd1);
        check("rst_outs", 32'({spi_sclk, spi_sdata, busy, done, err, man_ack,
                               init_reg, incr_reg, auto_run, pttn_sel}), 32'd0);
        rstb = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Auto sequence ending on the deskew word
        b_init = n_init; b_incr = n_incr; b_fr = n_frames;
        exp_q.push_back(24'h26AA80); exp_q.push_back(24'h275540); exp_q.push_back(24'h450001);
        pulse_start();
        check("auto_run_set", 32'(auto_run), 32'd1);
        wait_evt(0, 2000, "auto_done");
        check("auto_init_cnt", 32'(n_init - b_init), 32'd1);
        check("auto_incr_cnt", 32'(n_incr - b_incr), 32'd2);
        check("auto_frames", 32'(n_frames - b_fr), 32'd3);
        @(negedge clk);
        check("auto_run_clr", 32'(auto_run), 32'd0);
        check("auto_busy_clr", 32'(busy), 32'd0);

        // Manual writes, valid and invalid selector codes
        foreach (vecs[k]) begin
            pwdown_ch = vecs[k].pw;
            b_fr = n_frames; b_rise = n_rise; b_done = n_done;
            if (vecs[k].valid) exp_q.push_back(vecs[k].word);
            man_sel = vecs[k].sel;
            man_req = 1'b1;
            wait_evt(1, 10, "man_ack");
            check("man_err", 32'(err), 32'(!vecs[k].valid));
            if (vecs[k].valid) begin
                check("man_pttn_sel", 32'(pttn_sel), 32'(vecs[k].sel));
                check("man_auto_run", 32'(auto_run), 32'd0);
            end
            man_req = 1'b0;
            if (vecs[k].valid) begin
                wait_evt(0, 400, "man_done");
                check("man_frames", 32'(n_frames - b_fr), 32'd1);
            end else begin
                repeat (30) @(negedge clk);
                check("inv_no_sclk", 32'(n_rise - b_rise), 32'd0);
                check("inv_no_done", 32'(n_done - b_done), 32'd0);
                check("inv_busy", 32'({busy, spi_sen_n}), 32'b01);
            end
        end

        // start_auto and man_req together: auto first, manual acked after
        pwdown_ch = 8'h03; b_ack = n_ack; b_fr = n_frames;
        exp_q.push_back(24'h26AA80); exp_q.push_back(24'h275540);
        exp_q.push_back(24'h450001); exp_q.push_back(24'h0F0203);
        @(negedge clk);
        start_auto = 1'b1; man_req = 1'b1; man_sel = SEL_PWRDN;
        @(negedge clk);
        start_auto = 1'b0;
        wait_evt(0, 2000, "coll_auto_done");
        check("coll_no_early_ack", 32'(n_ack - b_ack), 32'd0);
        wait_evt(1, 10, "coll_man_ack");
        man_req = 1'b0;
        wait_evt(0, 400, "coll_man_done");
        check("coll_frames", 32'(n_frames - b_fr), 32'd4);

        // Auto abort: end_auto never asserted
        no_end = 1'b1; b_fr = n_frames; b_done = n_done; b_err = n_err;
        for (int i = 1; i <= int'(MAX_AUTO); i++) exp_q.push_back(auto_word(8'(i)));
        pulse_start();
        wait_evt(2, 3000, "abort_err");
        check("abort_done", 32'(n_done - b_done), 32'd0);
        @(negedge clk);
        check("abort_busy", 32'({busy, auto_run}), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_frames", 32'(n_frames - b_fr), 32'(MAX_AUTO));
        check("abort_err_cnt", 32'(n_err - b_err), 32'd1);
        no_end = 1'b0;

        // Reset in the middle of a frame
        man_sel = SEL_PWRDN; man_req = 1'b1;
        exp_q.push_back(24'h0F0203);
        wait_evt(1, 10, "rst_man_ack");
        man_req = 1'b0;
        wait_evt(3, 10, "rst_frame_start");
        repeat (50) @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        check("rst_async_spi", 32'({spi_sen_n, spi_sclk}), 32'b10);
        check("rst_async_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        b_rise = n_rise;
        repeat (60) @(negedge clk);
        check("post_rst_quiet", 32'(n_rise - b_rise), 32'd0);
        check("post_rst_idle", 32'({busy, spi_sen_n}), 32'b01);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
